sc_traffic_master: RTL and testbench
====================================

// Module: sc_traffic_master
// PURPOSE
//  Synthesizable, parametrised crossbar master that generates programmable req/ack traffic.
//  Supports write, read, write-then-readback and random write/read-pair modes.
//  Checks read data, counts mismatches and aborts on ack timeout.
//  Drives one master port of the sc round-robin crossbar, in place of file-driven stimulus, for soak and self-check runs.
// PARAMETERS
//  AW          32          address width
//  DW          32          data width (>= 8)
//  NUM_TXN     16          transactions per run (per pass in mode 2), >= 1
//  BASE_ADDR   32'h0       base byte address of the target window
//  SPAN_LOG2   8           word-offset bits; window = 2^SPAN_LOG2 words
//  TIMEOUT     255         max cycles o_req may wait for i_ack, >= 1
//  SEED        16'hACE1    LFSR seed (nonzero)
//  PATTERN     32'hA5A5_5A5A  data XOR pattern
// PORTS
//  i_clk        in   1   clock
//  i_resetb     in   1   asynchronous active-low reset
//  i_start      in   1   start pulse; sampled only in IDLE/DONE
//  i_mode       in   2   0=write, 1=read, 2=write pass then read pass, 3=random write+read pairs
//  i_gap        in   8   idle cycles between transactions; latched at start
//  o_req        out  1   request to crossbar
//  o_addr       out  AW  byte address, word aligned
//  o_cmd        out  1   1=write, 0=read
//  o_wdata      out  DW  write data (0 on reads)
//  i_ack        in   1   slave acknowledge; i_rdata valid in the same cycle
//  i_rdata      in   DW  read data
//  o_busy       out  1   high from start until DONE
//  o_done       out  1   level; high in DONE until the next start
//  o_err_cnt    out  16  read mismatches, saturating at 16'hFFFF
//  o_timeout    out  1   sticky; set on ack timeout, cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; o_req/o_cmd/o_busy/o_done/o_timeout=0; o_addr/o_wdata=0; o_err_cnt=0; LFSR=SEED.
//  Reset mid-transaction aborts immediately: o_req low, no count updates.
//  States: IDLE, REQ, GAP, DONE.
//  - IDLE/DONE + i_start: latch mode and gap; clear idx, err_cnt, timeout and done; LFSR=SEED.
//    Next cycle enter REQ with o_req=1 and the first txn's addr/cmd/wdata registered.
//  - REQ: o_req, o_addr, o_cmd and o_wdata are held stable until i_ack is sampled high.
//  - On the ack cycle:
//    - For reads, compare i_rdata to the expected data; on mismatch, err_cnt += 1 (saturating).
//    - In the following cycle o_req=0.
//    - If it was the last txn, go to DONE; else if gap>0, go to GAP; else go to REQ with the next txn.
//    - Minimum spacing is 1 idle cycle between reqs.
//  - GAP: count gap cycles with o_req=0, then go to REQ.
//  - Timeout: wait counter cleared on entry to REQ. If TIMEOUT cycles elapse without i_ack:
//    o_timeout=1, o_req=0 next cycle, go to DONE, skip remaining txns.
//  - DONE: o_busy=0, o_done=1. i_ack outside REQ is ignored. i_start while busy is ignored.
//  Address/data:
//  - Offset k (SPAN_LOG2 bits). o_addr = BASE_ADDR + (k << 2), truncated to AW bits; wraps within the window.
//  - Data D(a) = (a ^ PATTERN) truncated to DW bits.
//  Per-mode sequencing:
//  - Modes 0/1: k = idx mod 2^SPAN_LOG2; NUM_TXN writes of D(addr) or reads (unchecked).
//  - Mode 2: write pass idx 0..NUM_TXN-1, then read pass over the same addresses with check against D(addr).
//    Total 2*NUM_TXN txns.
//  - Mode 3: k = LFSR[SPAN_LOG2-1:0] (16-bit Fibonacci, taps 16,14,13,11). LFSR advances once per pair.
//    Each pair is a write of D(a) then a read of a, checked. Total 2*NUM_TXN txns.
//  - idx counter width $clog2(2*NUM_TXN+1); no overflow.
// TESTING
//  T1 reset: assert i_resetb=0 mid-REQ -> o_req=0 in same cycle, all outputs at reset values, state IDLE.
//  T2 mode 0, NUM_TXN=4, gap=0, slave acks after 2 cycles:
//     -> writes to 0x0,0x4,0x8,0xC, data 0xA5A55A5A,0xA5A55A5E,...; 1 idle cycle between reqs; o_done=1.
//  T3 mode 2, memory slave with word 0x8 corrupted to 0 on read -> 8 txns, o_err_cnt=1, o_timeout=0.
//  T4 SPAN_LOG2=2, mode 0, NUM_TXN=6 -> addresses 0x0,0x4,0x8,0xC,0x0,0x4 (wrap).
//  T5 slave never acks, TIMEOUT=10 -> o_req high exactly 10 cycles, then o_timeout=1, o_done=1, o_err_cnt=0.
//  T6 mode 3, gap=3, i_start re-pulsed while busy:
//     -> start ignored; >=3 idle cycles between reqs; each write is followed by a read to the same addr; o_err_cnt=0.

Source files
------------

// File: rtl/sc_traffic_master_if.sv
// Request/acknowledge bus between the traffic master and one crossbar master port.
// The slave side answers with ack; rdata is valid in the same cycle as ack.
interface sc_traffic_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          cmd;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output addr,
    output cmd,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    input  cmd,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/sc_traffic_master.sv
// Programmable req/ack traffic generator for one crossbar master port.
// Issues write/read/readback/random-pair runs, checks read data and aborts on ack timeout.
module sc_traffic_master #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned NUM_TXN   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned SPAN_LOG2 = 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [31:0] PATTERN   = 32'hA5A5_5A5A
) (
  input  logic                       i_clk,
  input  logic                       i_resetb,
  input  logic                       i_start,
  input  logic [1:0]                 i_mode,
  input  logic [7:0]                 i_gap,
  sc_traffic_master_if.master        bus_io,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [15:0]                o_err_cnt,
  output logic                       o_timeout
);

  localparam int unsigned IW = $clog2(2 * NUM_TXN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned XW = AW + DW + 32;

  typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [7:0]             gap_q, gap_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic [15:0]            err_q, err_d;
  logic                   tout_q, tout_d;
  logic                   req_q, req_d;
  logic                   cmd_q, cmd_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          wdata_q, wdata_d;

  logic [SPAN_LOG2-1:0]   nk;
  logic                   ncmd;
  logic [AW-1:0]          naddr;
  logic [IW-1:0]          last_idx;
  logic [7:0]             gap_eff;
  logic                   chk_rd;
  logic [15:0]            lfsr_next;

  function automatic logic [AW-1:0] word_addr(input logic [SPAN_LOG2-1:0] k);
    return AW'(BASE_ADDR) + (AW'(k) << 2);
  endfunction

  function automatic logic [DW-1:0] pat_data(input logic [AW-1:0] a);
    return DW'(XW'(a) ^ XW'(PATTERN));
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign last_idx = mode_q[1] ? IW'(2 * NUM_TXN - 1) : IW'(NUM_TXN - 1);
  assign gap_eff  = (gap_q == 8'd0) ? 8'd1 : gap_q;
  assign chk_rd   = ((mode_q == 2'd2) && (idx_q >= IW'(NUM_TXN))) ||
                    ((mode_q == 2'd3) && idx_q[0]);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    lfsr_d    = lfsr_q;
    wait_d    = wait_q;
    err_d     = err_q;
    tout_d    = tout_q;
    req_d     = req_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    nk        = '0;
    ncmd      = 1'b0;
    naddr     = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          mode_d  = i_mode;
          gap_d   = i_gap;
          idx_d   = '0;
          err_d   = '0;
          tout_d  = 1'b0;
          lfsr_d  = SEED;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus_io.ack) begin
          if (chk_rd && (bus_io.rdata != pat_data(addr_q)) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
          req_d = 1'b0;
          if ((mode_q == 2'd3) && idx_q[0]) begin
            lfsr_d = lfsr_next;
          end
          if (idx_q == last_idx) begin
            state_d = StDone;
          end else begin
            idx_d     = idx_q + IW'(1);
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          req_d   = 1'b0;
          state_d = StDone;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      StGap: begin
        // A zero gap still leaves one idle cycle between requests
        if (gap_cnt_q == gap_eff - 8'd1) begin
          state_d = StReq;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    // Transaction selected by the post-update index/mode/LFSR
    unique case (mode_d)
      2'd0: begin
        nk   = SPAN_LOG2'(idx_d);
        ncmd = 1'b1;
      end
      2'd1: begin
        nk   = SPAN_LOG2'(idx_d);
        ncmd = 1'b0;
      end
      2'd2: begin
        if (idx_d < IW'(NUM_TXN)) begin
          nk   = SPAN_LOG2'(idx_d);
          ncmd = 1'b1;
        end else begin
          nk   = SPAN_LOG2'(idx_d - IW'(NUM_TXN));
          ncmd = 1'b0;
        end
      end
      default: begin
        nk   = SPAN_LOG2'(lfsr_d);
        ncmd = ~idx_d[0];
      end
    endcase
    naddr = word_addr(nk);

    if ((state_d == StReq) && (state_q != StReq)) begin
      req_d   = 1'b1;
      wait_d  = '0;
      addr_d  = naddr;
      cmd_d   = ncmd;
      wdata_d = ncmd ? pat_data(naddr) : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      state_q   <= StIdle;
      mode_q    <= 2'd0;
      gap_q     <= 8'd0;
      gap_cnt_q <= 8'd0;
      idx_q     <= '0;
      lfsr_q    <= SEED;
      wait_q    <= '0;
      err_q     <= 16'd0;
      tout_q    <= 1'b0;
      req_q     <= 1'b0;
      cmd_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
      lfsr_q    <= lfsr_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      tout_q    <= tout_d;
      req_q     <= req_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus_io.req   = req_q;
  assign bus_io.addr  = addr_q;
  assign bus_io.cmd   = cmd_q;
  assign bus_io.wdata = wdata_q;

  assign o_busy    = (state_q == StReq) || (state_q == StGap);
  assign o_done    = (state_q == StDone);
  assign o_err_cnt = err_q;
  assign o_timeout = tout_q;

endmodule

// File: tb/tb_sc_traffic_master.sv
// Bench for sc_traffic_master: memory slave with programmable latency/corruption and a
// transaction-list reference model checked every cycle on the falling edge.
module tb_sc_traffic_master;

  localparam int NTXN = 6;
  localparam int TOUT = 10;
  localparam logic [31:0] PAT = 32'hA5A5_5A5A;

  typedef struct packed {
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        chk;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [7:0]  i_gap;
  logic        busy, done, tout;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  sc_traffic_master_if #(.AW(32), .DW(32)) bus ();

  sc_traffic_master #(
    .AW(32), .DW(32), .NUM_TXN(NTXN), .BASE_ADDR(32'h0), .SPAN_LOG2(2),
    .TIMEOUT(TOUT), .SEED(16'hACE1), .PATTERN(PAT)
  ) dut (
    .i_clk    (clk),
    .i_resetb (rst_n),
    .i_start  (i_start),
    .i_mode   (i_mode),
    .i_gap    (i_gap),
    .bus_io   (bus),
    .o_busy   (busy),
    .o_done   (done),
    .o_err_cnt(err_cnt),
    .o_timeout(tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ PAT;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  // ---------------- memory slave ----------------
  int          lat_fix = 2;
  bit          lat_rand = 0;
  bit          never_ack = 0;
  bit          corrupt8 = 0;
  int          corrupt_pct = 0;
  int          scnt = 0;
  int          lat_cur = 2;
  logic [31:0] mem [4];
  logic [31:0] rd;

  always @(posedge clk) begin
    #1;
    if (!rst_n || !bus.req) begin
      bus.ack   = 1'b0;
      bus.rdata = '0;
      scnt      = 0;
    end else if (bus.ack) begin
      bus.ack = 1'b0;
    end else if (!never_ack && scnt >= lat_cur) begin
      bus.ack = 1'b1;
      if (bus.cmd) begin
        mem[bus.addr[3:2]] = bus.wdata;
        bus.rdata = $urandom;
      end else begin
        rd = mem[bus.addr[3:2]];
        if (corrupt8 && bus.addr == 32'h8) rd = 32'h0;
        if ($urandom_range(0, 99) < corrupt_pct) rd = rd ^ 32'h1;
        bus.rdata = rd;
      end
      lat_cur = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
    end else begin
      scnt++;
    end
  end

  // ---------------- reference model + compare ----------------
  txn_t        exp_q[$];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  int          phase = 0;  // 0 idle, 1 running, 2 finished
  int          pos, idle, req_run, last_run, n_acks, gap_exp;
  int          exp_err;
  bit          exp_tout;

  task automatic build_exp(input logic [1:0] m);
    logic [15:0] l;
    int n, k;
    txn_t t;
    exp_q.delete();
    l = 16'hACE1;
    n = (m >= 2) ? 2 * NTXN : NTXN;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'd0: begin k = i % 4; t.cmd = 1'b1; t.chk = 1'b0; end
        2'd1: begin k = i % 4; t.cmd = 1'b0; t.chk = 1'b0; end
        2'd2: begin
          k = (i < NTXN) ? i % 4 : (i - NTXN) % 4;
          t.cmd = (i < NTXN);
          t.chk = (i >= NTXN);
        end
        default: begin
          k = int'(l % 16'd4);
          t.cmd = (i % 2 == 0);
          t.chk = (i % 2 == 1);
          if (i % 2 == 1) l = lfsr_step(l);
        end
      endcase
      t.addr  = 32'(k * 4);
      t.wdata = t.cmd ? pat(t.addr) : 32'h0;
      exp_q.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      phase   = 0;
      req_run = 0;
      idle    = 0;
    end else if (phase == 1) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("timeout_run", tout, 0);
      chk("err_run", err_cnt, exp_err);
      if (bus.req) begin
        if (pos >= exp_q.size()) begin
          chk("extra_req", pos, exp_q.size());
        end else begin
          if (req_run == 0 && pos > 0) chk("spacing", idle, gap_exp);
          chk("addr", bus.addr, exp_q[pos].addr);
          chk("cmd", bus.cmd, exp_q[pos].cmd);
          chk("wdata", bus.wdata, exp_q[pos].wdata);
          req_run++;
          idle = 0;
          if (bus.ack) begin
            if (exp_q[pos].chk && bus.rdata !== pat(bus.addr) && exp_err < 65535) exp_err++;
            if (bus.cmd) begin
              wlog_a.push_back(bus.addr);
              wlog_d.push_back(bus.wdata);
            end
            n_acks++;
            last_run = req_run;
            req_run  = 0;
            pos++;
            if (pos == exp_q.size()) phase = 2;
          end else if (req_run == TOUT) begin
            exp_tout = 1'b1;
            last_run = req_run;
            req_run  = 0;
            phase    = 2;
          end
        end
      end else begin
        idle++;
      end
    end else begin
      if (phase == 2) begin
        chk("busy_done", busy, 0);
        chk("done_done", done, 1);
        chk("req_done", bus.req, 0);
        chk("err_done", err_cnt, exp_err);
        chk("timeout_done", tout, exp_tout);
      end
      if (i_start) begin
        phase    = 1;
        pos      = 0;
        idle     = 0;
        req_run  = 0;
        exp_err  = 0;
        exp_tout = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic [1:0] m, input logic [7:0] g, input bit mid_start);
    int c;
    build_exp(m);
    gap_exp = (g == 8'd0) ? 1 : int'(g);
    wlog_a.delete();
    wlog_d.delete();
    n_acks = 0;
    @(posedge clk); #2;
    i_mode  = m;
    i_gap   = g;
    i_start = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    i_mode  = 2'($urandom);
    i_gap   = 8'($urandom);
    c = 0;
    while (phase != 2 && c < 3000) begin
      @(posedge clk);
      c++;
      if (mid_start && c == 15) begin
        #2 i_start = 1'b1;
        @(posedge clk);
        #2 i_start = 1'b0;
        c++;
      end
    end
    chk("run_end", phase, 2);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int c;
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_mode    = 2'd0;
    i_gap     = 8'd0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    #3;
    chk("rst_req", bus.req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_addr", bus.addr, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // T1: reset asserted while a request is outstanding
    lat_fix = 6;
    lat_cur = 6;
    build_exp(2'd0);
    @(posedge clk); #2;
    i_start = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    c = 0;
    while (!bus.req && c < 50) begin
      @(posedge clk); #2;
      c++;
    end
    chk("t1_req_seen", bus.req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_req", bus.req, 0);
    chk("t1_addr", bus.addr, 0);
    chk("t1_cmd", bus.cmd, 0);
    chk("t1_wdata", bus.wdata, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_timeout", tout, 0);
    chk("t1_err", err_cnt, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // T2 + T4: mode 0, gap 0, ack after 2 cycles, window of 4 words wraps
    lat_fix = 2;
    lat_cur = 2;
    run(2'd0, 8'd0, 1'b0);
    chk("t2_nwr", wlog_a.size(), 6);
    if (wlog_a.size() == 6) begin
      chk("t2_a0", wlog_a[0], 32'h0);
      chk("t2_a1", wlog_a[1], 32'h4);
      chk("t2_a2", wlog_a[2], 32'h8);
      chk("t2_a3", wlog_a[3], 32'hC);
      chk("t4_a4", wlog_a[4], 32'h0);
      chk("t4_a5", wlog_a[5], 32'h4);
      chk("t2_d0", wlog_d[0], 32'hA5A55A5A);
      chk("t2_d1", wlog_d[1], 32'hA5A55A5E);
      chk("t2_d2", wlog_d[2], 32'hA5A55A52);
      chk("t2_d3", wlog_d[3], 32'hA5A55A56);
    end
    chk("t2_done", done, 1);

    // T3: write then readback with word 0x8 corrupted
    corrupt8 = 1;
    run(2'd2, 8'd0, 1'b0);
    chk("t3_txns", n_acks, 12);
    chk("t3_err", err_cnt, 1);
    chk("t3_timeout", tout, 0);
    corrupt8 = 0;

    // T5: slave never acknowledges
    never_ack = 1;
    run(2'd0, 8'd1, 1'b0);
    chk("t5_req_len", last_run, 10);
    chk("t5_timeout", tout, 1);
    chk("t5_done", done, 1);
    chk("t5_err", err_cnt, 0);
    never_ack = 0;

    // T6: random pairs, gap 3, start re-pulsed while busy
    lat_rand = 1;
    run(2'd3, 8'd3, 1'b1);
    chk("t6_txns", n_acks, 12);
    chk("t6_err", err_cnt, 0);
    if (wlog_a.size() >= 2) begin
      chk("t6_pair0", wlog_a[0], 32'h4);
      chk("t6_pair1", wlog_a[1], 32'h0);
    end

    // Randomized runs with random latency and read corruption
    corrupt_pct = 20;
    for (int r = 0; r < 10; r++) begin
      run(2'($urandom), 8'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
